// File: rtl/imem_if.sv
// Instruction memory bus: the fetch unit drives address and read strobe,
// memory returns the instruction word qualified by rdy.
interface imem_if #(
   parameter int AW = 16
);
   logic [AW-1:0] addr;
   logic          rd;
   logic [31:0]   data;
   logic          rdy;

   modport master (output addr, output rd, input data, input rdy);
   modport slave  (input addr, input rd, output data, output rdy);
endinterface

// File: rtl/fetch_unit.sv
// SISC fetch/PC stage: owns pc and ir, runs the wait-state handshake with
// instruction memory and resolves conditional branches on request from ctrl.
module fetch_unit #(
   parameter int PC_W     = 16,
   parameter int WAIT_MAX = 15
) (
   input  logic            clk,
   input  logic            rst_f,
   input  logic            fetch_go,
   input  logic            br_go,
   input  logic [3:0]      stat,
   imem_if.master          imem,
   output logic [PC_W-1:0] pc,
   output logic [31:0]     ir,
   output logic [3:0]      opcode,
   output logic [3:0]      mm,
   output logic [15:0]     imm,
   output logic            fetch_done,
   output logic            busy,
   output logic            fetch_err,
   output logic            br_taken
);

   localparam int CNT_W = $clog2(WAIT_MAX + 1);

   typedef enum logic {
      IDLE,
      REQ
   } state_e;

   state_e           state_q, state_d;
   logic [PC_W-1:0]  pc_q, pc_d;
   logic [31:0]      ir_q, ir_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             done_q, done_d;
   logic             err_q, err_d;
   logic             brt_q, brt_d;

   logic             cond;
   logic             br_take;
   logic [PC_W-1:0]  br_abs;
   logic [PC_W-1:0]  br_rel;
   logic [PC_W-1:0]  br_tgt;

   always_ff @(posedge clk or negedge rst_f) begin
      if (!rst_f) begin
         state_q <= IDLE;
         pc_q    <= '0;
         ir_q    <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         brt_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         err_q   <= err_d;
         brt_q   <= brt_d;
      end
   end

   // Branch target and decision, evaluated against the current ir and pc
   always_comb begin
      cond    = |(stat & ir_q[27:24]);
      br_abs  = PC_W'({16'h0000, ir_q[15:0]});
      br_rel  = pc_q + PC_W'({{16{ir_q[15]}}, ir_q[15:0]});
      br_take = 1'b0;
      br_tgt  = pc_q;
      case (ir_q[31:28])
         4'd4: begin br_take = cond;  br_tgt = br_abs; end
         4'd5: begin br_take = cond;  br_tgt = br_rel; end
         4'd6: begin br_take = !cond; br_tgt = br_abs; end
         4'd7: begin br_take = !cond; br_tgt = br_rel; end
         default: begin br_take = 1'b0; br_tgt = pc_q; end
      endcase
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      err_d   = err_q;
      brt_d   = brt_q;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (fetch_go) begin
               state_d = REQ;
               err_d   = 1'b0;
               brt_d   = 1'b0;
            end
            // A simultaneous branch wins br_taken and feeds its pc to the fetch
            if (br_go) begin
               brt_d = br_take;
               if (br_take) pc_d = br_tgt;
            end
         end
         REQ: begin
            if (imem.rdy) begin
               ir_d    = imem.data;
               pc_d    = pc_q + PC_W'(1);
               done_d  = 1'b1;
               state_d = IDLE;
            end else if (cnt_q == CNT_W'(WAIT_MAX - 1)) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign imem.addr  = pc_q;
   assign imem.rd    = (state_q == REQ);
   assign busy       = (state_q == REQ);
   assign pc         = pc_q;
   assign ir         = ir_q;
   assign opcode     = ir_q[31:28];
   assign mm         = ir_q[27:24];
   assign imm        = ir_q[15:0];
   assign fetch_done = done_q;
   assign fetch_err  = err_q;
   assign br_taken   = brt_q;

endmodule
